// File: rtl/generic_bus_pkg.sv
// Shared types and helpers for the GenericBus wait-state memory.
// Contents:
//   mem_state_t  - transfer sequencer states
//   burst_type_t - burst kind as carried on the bus (informational only)
//   PROT_PRIV    - bit of prot that marks a privileged access
//   wait_count   - selects the wait-state count for a beat
package generic_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SINGLE = 2'd0,
    INCR   = 2'd1,
    WRAP   = 2'd2
  } burst_type_t;

  localparam int PROT_PRIV = 0;

  // First beats (and single transfers) use the full wait count; burst
  // continuation beats use the burst wait count.
  function automatic logic [3:0] wait_count(input logic first,
                                            input logic [3:0] ws,
                                            input logic [3:0] bws);
    return first ? ws : bws;
  endfunction

endpackage

// File: rtl/generic_bus_if.sv
// GenericBus subordinate-side connection.
// Handshake: a request is rEn or wEn high. The manager holds every request
// field stable until the transfer completes, which happens at the rising
// edge where the request is present and busy is 0. rData and error are only
// meaningful (and only non-zero) in that completing cycle.
// Signals:
//   addr, wData, wStrb, wEn, rEn, isBurst, burstType, burstLen, nonSec, prot
//                  - manager to memory
//   rData, error, busy - memory to manager
//   dbg_state      - current sequencer state, for observation only
interface GenericBus_if
  import generic_bus_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) ();

  logic [AddrWidth-1:0]   addr;
  logic [DataWidth-1:0]   wData;
  logic [DataWidth/8-1:0] wStrb;
  logic                   wEn;
  logic                   rEn;
  logic                   isBurst;
  burst_type_t            burstType;
  logic [7:0]             burstLen;
  logic                   nonSec;
  logic [2:0]             prot;
  logic [DataWidth-1:0]   rData;
  logic                   error;
  logic                   busy;
  mem_state_t             dbg_state;

  modport master (
    output addr, wData, wStrb, wEn, rEn, isBurst, burstType, burstLen,
           nonSec, prot,
    input  rData, error, busy, dbg_state
  );

  modport slave (
    input  addr, wData, wStrb, wEn, rEn, isBurst, burstType, burstLen,
           nonSec, prot,
    output rData, error, busy, dbg_state
  );

endinterface

// File: rtl/generic_bus_mem_array.sv
// Depth x DataWidth storage with per-byte write strobes.
// Write is synchronous, read is asynchronous. Contents are never reset.
// Ports:
//   clk_i   - clock
//   we_i    - write enable (already qualified by the caller)
//   idx_i   - word index, shared by read and write
//   strb_i  - byte lane enables for the write
//   wdata_i - write data
//   rdata_o - word at idx_i
module generic_bus_mem_array #(
  parameter int DataWidth = 32,
  parameter int Depth     = 256,
  localparam int IdxW     = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [IdxW-1:0]        idx_i,
  input  logic [DataWidth/8-1:0] strb_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic [DataWidth-1:0]   rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DataWidth / 8; b++) begin
        if (strb_i[b]) begin
          mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/generic_bus_wait_mem.sv
// GenericBus memory with configurable wait states, burst-aware wait
// selection and access checking.
// Ports:
//   clk    - clock, rising edge
//   nReset - synchronous active-low reset
//   bus    - GenericBus subordinate side (see GenericBus_if)
module generic_bus_wait_mem
  import generic_bus_pkg::*;
#(
  parameter int DataWidth       = 32,
  parameter int AddrWidth       = 32,
  parameter int Depth           = 256,
  parameter int WaitStates      = 2,
  parameter int BurstWaitStates = 0,
  parameter int ReadOnly        = 0
) (
  input  logic    clk,
  input  logic    nReset,
  GenericBus_if.slave bus
);

  localparam int OffBits = (DataWidth > 8) ? $clog2(DataWidth / 8) : 0;
  localparam int IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrWidth-1:0] LaneMask = AddrWidth'(DataWidth / 8 - 1);
  localparam logic [3:0] Ws  = 4'(WaitStates);
  localparam logic [3:0] Bws = 4'(BurstWaitStates);

  mem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] beats_q, beats_d;
  logic       in_burst_q, in_burst_d;

  logic                 req;
  logic [AddrWidth-1:0] word_idx;
  logic                 err_cond;
  logic                 continuation;
  logic [3:0]           wait_sel;
  logic                 busy_c;
  logic                 complete;
  logic                 wr_en;
  logic [DataWidth-1:0] arr_rdata;

  assign req      = bus.wEn | bus.rEn;
  assign word_idx = bus.addr >> OffBits;

  // The lowest eighth of the array only accepts privileged writes.
  assign err_cond = (word_idx >= AddrWidth'(Depth))
                  || ((bus.addr & LaneMask) != '0)
                  || (bus.wEn && bus.rEn)
                  || (bus.wEn && (ReadOnly != 0))
                  || (bus.wEn && !bus.prot[PROT_PRIV]
                      && (word_idx < AddrWidth'(Depth / 8)));

  assign continuation = bus.isBurst && in_burst_q && (beats_q != 8'd0);
  assign wait_sel     = wait_count(!continuation, Ws, Bws);

  // Sequencer. The IDLE request cycle is itself the first busy cycle, so
  // a wait count of N gives exactly N busy cycles before DONE. With N=1
  // there is no WAIT cycle left to spend, so IDLE goes straight to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && (wait_sel != 4'd0)) begin
          busy_c  = 1'b1;
          cnt_d   = wait_sel - 4'd1;
          state_d = (wait_sel == 4'd1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        busy_c = 1'b1;
        if (!req) begin
          // Request withdrawn: abandon quietly.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign complete = nReset && req && !busy_c;
  assign wr_en    = complete && bus.wEn && !err_cond;

  // Burst tracker, updated only on completed transfers.
  always_comb begin
    beats_d    = beats_q;
    in_burst_d = in_burst_q;
    if (complete) begin
      if (err_cond) begin
        beats_d    = 8'd0;
        in_burst_d = 1'b0;
      end else if (continuation) begin
        beats_d    = beats_q - 8'd1;
        in_burst_d = (beats_q != 8'd1);
      end else if (bus.isBurst) begin
        beats_d    = bus.burstLen;
        in_burst_d = (bus.burstLen != 8'd0);
      end else begin
        beats_d    = 8'd0;
        in_burst_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      beats_q    <= 8'd0;
      in_burst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beats_q    <= beats_d;
      in_burst_q <= in_burst_d;
    end
  end

  generic_bus_mem_array #(
    .DataWidth(DataWidth),
    .Depth    (Depth)
  ) u_array (
    .clk_i  (clk),
    .we_i   (wr_en),
    .idx_i  (word_idx[IdxW-1:0]),
    .strb_i (bus.wStrb),
    .wdata_i(bus.wData),
    .rdata_o(arr_rdata)
  );

  assign bus.busy      = nReset && busy_c;
  assign bus.error     = complete && err_cond;
  assign bus.rData     = (complete && bus.rEn && !err_cond) ? arr_rdata : '0;
  assign bus.dbg_state = state_q;

  // Carried on the bus but not interpreted by this device.
  logic unused_bus;
  assign unused_bus = ^{bus.burstType, bus.nonSec, bus.prot[2:1]};

endmodule

// File: tb/tb_generic_bus_wait_mem.sv
module tb_generic_bus_wait_mem;
  import generic_bus_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;
  localparam int W     = DW + 1 + 5;  // {wait[4:0], error, rdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared drive, steered by d_sel ----------------
  int          d_sel = 0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_strb = '0;
  logic        d_wen = 1'b0;
  logic        d_ren = 1'b0;
  logic        d_isb = 1'b0;
  logic [7:0]  d_blen = '0;
  logic [2:0]  d_prot = '0;

  GenericBus_if #(.DataWidth(DW), .AddrWidth(AW)) bus_a ();
  GenericBus_if #(.DataWidth(DW), .AddrWidth(AW)) bus_b ();

  assign bus_a.addr      = d_addr;
  assign bus_a.wData     = d_wdata;
  assign bus_a.wStrb     = d_strb;
  assign bus_a.wEn       = d_wen && (d_sel == 0);
  assign bus_a.rEn       = d_ren && (d_sel == 0);
  assign bus_a.isBurst   = d_isb;
  assign bus_a.burstType = d_isb ? INCR : SINGLE;
  assign bus_a.burstLen  = d_blen;
  assign bus_a.nonSec    = 1'b0;
  assign bus_a.prot      = d_prot;

  assign bus_b.addr      = d_addr;
  assign bus_b.wData     = d_wdata;
  assign bus_b.wStrb     = d_strb;
  assign bus_b.wEn       = d_wen && (d_sel == 1);
  assign bus_b.rEn       = d_ren && (d_sel == 1);
  assign bus_b.isBurst   = d_isb;
  assign bus_b.burstType = d_isb ? INCR : SINGLE;
  assign bus_b.burstLen  = d_blen;
  assign bus_b.nonSec    = 1'b0;
  assign bus_b.prot      = d_prot;

  generic_bus_wait_mem #(
    .DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH),
    .WaitStates(2), .BurstWaitStates(0), .ReadOnly(0)
  ) u_dut_a (
    .clk   (clk),
    .nReset(nReset),
    .bus   (bus_a)
  );

  generic_bus_wait_mem #(
    .DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH),
    .WaitStates(0), .BurstWaitStates(1), .ReadOnly(0)
  ) u_dut_b (
    .clk   (clk),
    .nReset(nReset),
    .bus   (bus_b)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_mem [2][DEPTH];
  int          m_ws  [2] = '{2, 0};
  int          m_bws [2] = '{0, 1};
  bit          m_inb [2] = '{1'b0, 1'b0};
  int          m_beats [2] = '{0, 0};

  function automatic logic [W-1:0] model_xfer(input int sel, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] strb,
                                               input logic wen, input logic ren,
                                               input logic [2:0] prot, input logic isb,
                                               input logic [7:0] blen);
    int unsigned idx;
    logic        err;
    logic        cont;
    int          wt;
    logic [31:0] rd;
    idx  = addr / 4;
    err  = (idx >= DEPTH) || (addr % 4 != 0) || (wen && ren)
        || (wen && !prot[0] && (idx < DEPTH / 8));
    cont = isb && m_inb[sel] && (m_beats[sel] > 0);
    wt   = cont ? m_bws[sel] : m_ws[sel];
    rd   = '0;
    if (!err && ren) rd = m_mem[sel][idx];
    if (!err && wen) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_mem[sel][idx][8*b +: 8] = wdata[8*b +: 8];
    end
    if (err) begin
      m_inb[sel] = 1'b0; m_beats[sel] = 0;
    end else if (cont) begin
      m_beats[sel] = m_beats[sel] - 1;
      if (m_beats[sel] == 0) m_inb[sel] = 1'b0;
    end else if (isb) begin
      m_beats[sel] = int'(blen);
      m_inb[sel]   = (blen != 0);
    end else begin
      m_inb[sel] = 1'b0; m_beats[sel] = 0;
    end
    return {5'(wt), err, rd};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Monitor: pops an expectation whenever the selected device completes.
  int          busy_cnt = 0;
  logic        s_busy, s_err, o_err;
  logic [31:0] s_rd, o_rd;
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (nReset) begin
      s_busy = (d_sel == 0) ? bus_a.busy  : bus_b.busy;
      s_err  = (d_sel == 0) ? bus_a.error : bus_b.error;
      s_rd   = (d_sel == 0) ? bus_a.rData : bus_b.rData;
      o_err  = (d_sel == 0) ? bus_b.error : bus_a.error;
      o_rd   = (d_sel == 0) ? bus_b.rData : bus_a.rData;
      chk("unselected_error", 32'(o_err), 32'd0);
      chk("unselected_rdata", o_rd, 32'd0);
      if (d_wen || d_ren) begin
        if (s_busy) begin
          busy_cnt++;
          chk("busy_error", 32'(s_err), 32'd0);
          chk("busy_rdata", s_rd, 32'd0);
        end else begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rdata", s_rd, e[31:0]);
            chk("error", 32'(s_err), 32'(e[32]));
            chk("wait_cycles", 32'(busy_cnt), 32'(e[W-1 -: 5]));
          end
          busy_cnt = 0;
        end
      end else begin
        chk("noreq_error", 32'(s_err), 32'd0);
        chk("noreq_rdata", s_rd, 32'd0);
        busy_cnt = 0;
      end
    end else begin
      busy_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the completing edge.
  task automatic do_xfer(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic wen, input logic ren,
                         input logic [2:0] prot, input logic isb, input logic [7:0] blen);
    logic done_s;
    exp_q.push_back(model_xfer(sel, addr, wdata, strb, wen, ren, prot, isb, blen));
    d_sel = sel; d_addr = addr; d_wdata = wdata; d_strb = strb;
    d_wen = wen; d_ren = ren; d_prot = prot; d_isb = isb; d_blen = blen;
    done_s = 1'b0;
    for (int i = 0; i < 40 && !done_s; i++) begin
      @(negedge clk);
      if (!((sel == 0) ? bus_a.busy : bus_b.busy)) done_s = 1'b1;
    end
    if (!done_s) begin
      chk("completion_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
    end
    @(posedge clk); #1;
    d_wen = 1'b0; d_ren = 1'b0; d_isb = 1'b0;
  endtask

  task automatic rd(input int sel, input logic [31:0] addr);
    do_xfer(sel, addr, $urandom, 4'hF, 1'b0, 1'b1, 3'b001, 1'b0, 8'd0);
  endtask

  task automatic wr(input int sel, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [2:0] prot);
    do_xfer(sel, addr, data, strb, 1'b1, 1'b0, prot, 1'b0, 8'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'($urandom_range(DEPTH, DEPTH + 150) * 4);
    if (k == 1) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    // reset state
    repeat (3) begin
      @(negedge clk);
      chk("reset_busy_a", 32'(bus_a.busy), 32'd0);
      chk("reset_busy_b", 32'(bus_b.busy), 32'd0);
      chk("reset_error_a", 32'(bus_a.error), 32'd0);
      chk("reset_rdata_a", bus_a.rData, 32'd0);
    end
    @(posedge clk); #1;
    nReset = 1'b1;

    // preload both arrays
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++)
        wr(s, 32'(i * 4), $urandom, 4'hF, 3'b001);

    // read after write
    wr(0, 32'h20, 32'hDEADBEEF, 4'hF, 3'b001);
    rd(0, 32'h20);

    // byte strobes
    wr(0, 32'h40, 32'h11223344, 4'hF, 3'b001);
    wr(0, 32'h40, 32'hAABBCCDD, 4'b0101, 3'b001);
    rd(0, 32'h40);

    // burst: first beat waits, continuation beats do not, then single waits
    do_xfer(0, 32'h80, '0, 4'hF, 1'b0, 1'b1, 3'b001, 1'b1, 8'd3);
    do_xfer(0, 32'h84, '0, 4'hF, 1'b0, 1'b1, 3'b001, 1'b1, 8'd3);
    do_xfer(0, 32'h88, '0, 4'hF, 1'b0, 1'b1, 3'b001, 1'b1, 8'd3);
    do_xfer(0, 32'h8C, '0, 4'hF, 1'b0, 1'b1, 3'b001, 1'b1, 8'd3);
    rd(0, 32'h90);

    // errors
    rd(0, 32'h400);
    wr(0, 32'h22, 32'h12345678, 4'hF, 3'b001);
    rd(0, 32'h20);
    do_xfer(0, 32'h10, 32'h55AA55AA, 4'hF, 1'b1, 1'b1, 3'b001, 1'b0, 8'd0);
    wr(0, 32'h04, 32'hCAFEF00D, 4'hF, 3'b000);
    rd(0, 32'h04);
    wr(0, 32'h100, 32'hCAFEF00D, 4'hF, 3'b000);
    rd(0, 32'h100);
    wr(0, 32'h24, 32'h0BADC0DE, 4'h0, 3'b001);
    rd(0, 32'h24);

    // reset in the second busy cycle of a write to 0x30
    d_sel = 0; d_addr = 32'h30; d_wdata = 32'hFFFF0000; d_strb = 4'hF;
    d_wen = 1'b1; d_ren = 1'b0; d_prot = 3'b001; d_isb = 1'b0;
    @(posedge clk); #1;
    nReset = 1'b0; d_wen = 1'b0;
    @(posedge clk); #1;
    nReset = 1'b1;
    m_inb = '{1'b0, 1'b0}; m_beats = '{0, 0};
    @(negedge clk);
    chk("post_reset_busy", 32'(bus_a.busy), 32'd0);
    chk("post_reset_error", 32'(bus_a.error), 32'd0);
    chk("post_reset_rdata", bus_a.rData, 32'd0);
    @(posedge clk); #1;
    rd(0, 32'h30);

    // request withdrawn during WAIT: recovers, nothing written
    d_sel = 0; d_addr = 32'h34; d_wdata = 32'h01010101; d_strb = 4'hF;
    d_wen = 1'b1; d_prot = 3'b001;
    @(posedge clk); #1;
    d_wen = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("withdraw_busy", 32'(bus_a.busy), 32'd0);
    @(posedge clk); #1;
    rd(0, 32'h34);

    // zero-wait device: back-to-back reads, then a burst
    rd(1, 32'h00);
    rd(1, 32'h04);
    do_xfer(1, 32'h10, 32'h11111111, 4'hF, 1'b1, 1'b0, 3'b001, 1'b1, 8'd2);
    do_xfer(1, 32'h14, 32'h22222222, 4'hF, 1'b1, 1'b0, 3'b001, 1'b1, 8'd2);
    do_xfer(1, 32'h18, 32'h33333333, 4'hF, 1'b1, 1'b0, 3'b001, 1'b1, 8'd2);
    rd(1, 32'h14);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      int          sel;
      int          nb;
      int          k;
      logic        isb;
      logic        wen;
      logic        ren;
      logic [2:0]  prot;
      logic [31:0] base;
      sel  = $urandom_range(0, 1);
      isb  = ($urandom_range(0, 4) == 0);
      nb   = isb ? $urandom_range(1, 4) : 1;
      base = rand_addr();
      for (int b = 0; b < nb; b++) begin
        k    = $urandom_range(0, 9);
        wen  = (k <= 4);
        ren  = (k == 0) || (k >= 5);
        prot = ($urandom_range(0, 3) == 0) ? 3'b000 : (3'b001 | 3'($urandom_range(0, 7) & 6));
        do_xfer(sel, base + 32'(4 * b), $urandom, 4'($urandom_range(0, 15)),
                wen, ren, prot, isb, 8'(nb - 1));
      end
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
